// File: rtl/iob_cpu_bridge.sv
// iob_cpu_bridge: forwards a native CPU request (valid/ready handshake) to the
// instruction bus or to one of N_SLAVES data targets. The data target is chosen
// by the top SEL_W address bits, and an out-of-range select is answered locally
// with an error. Request fields are registered once and broadcast to every target.
// Optional bus timeout: define IOB_CPU_BRIDGE_TIMEOUT_EN.
module iob_cpu_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int N_SLAVES    = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_valid,
  input  logic                       cpu_instr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic [DATA_W/8-1:0]        cpu_wstrb,
  output logic                       cpu_ready,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       ibus_valid,
  input  logic                       ibus_ready,
  input  logic [DATA_W-1:0]          ibus_rdata,
  output logic [N_SLAVES-1:0]        dbus_valid,
  input  logic [N_SLAVES-1:0]        dbus_ready,
  input  logic [N_SLAVES*DATA_W-1:0] dbus_rdata,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       bus_err,
  input  logic                       err_clr
);

  localparam int SEL_W = $clog2(N_SLAVES);
  localparam int SEL_N = 1 << SEL_W;
  localparam logic [DATA_W-1:0] TMO_RDATA = DATA_W'(32'hDEADBEEF);

  if (N_SLAVES < 2) begin : g_bad_n_slaves
    $error("iob_cpu_bridge: N_SLAVES must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("iob_cpu_bridge: TIMEOUT_CYC must be at least 1");
  end

  // Bit i set when select value i addresses an existing data target.
  function automatic logic [SEL_N-1:0] sel_ok_mask();
    logic [SEL_N-1:0] m;
    for (int i = 0; i < SEL_N; i++) begin
      m[i] = (i < N_SLAVES);
    end
    return m;
  endfunction

  localparam logic [SEL_N-1:0] SEL_OK = sel_ok_mask();

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
  logic                instr_q, instr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                ibus_valid_q, ibus_valid_d;
  logic [N_SLAVES-1:0] dbus_valid_q, dbus_valid_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;

  logic [SEL_W-1:0]    cpu_sel;
  logic                tgt_ready;
  logic [DATA_W-1:0]   tgt_rdata;
  logic                err_set;
  logic                tmo_hit;

  assign cpu_sel = cpu_addr[ADDR_W-1 -: SEL_W];

`ifdef IOB_CPU_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // The counter sits at TIMEOUT_CYC-1 during the last REQ cycle that is allowed.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Count REQ cycles spent without a ready; cleared in every other state.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_REQ && !tgt_ready && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Select the ready/rdata pair of the target owning the current request.
  always_comb begin
    tgt_ready = 1'b0;
    tgt_rdata = '0;
    if (instr_q) begin
      tgt_ready = ibus_ready;
      tgt_rdata = ibus_rdata;
    end else begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (sel_q == SEL_W'(i)) begin
          tgt_ready = dbus_ready[i];
          tgt_rdata = dbus_rdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/REQ/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    instr_d      = instr_q;
    sel_d        = sel_q;
    ibus_valid_d = ibus_valid_q;
    dbus_valid_d = dbus_valid_q;
    rdata_d      = rdata_q;
    cpu_ready_d  = 1'b0;
    err_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          m_addr_d  = cpu_addr;
          m_wdata_d = cpu_wdata;
          m_wstrb_d = cpu_wstrb;
          instr_d   = cpu_instr;
          sel_d     = cpu_sel;
          if (!cpu_instr && !SEL_OK[cpu_sel]) begin
            // Nothing lives at this select: answer at once with zero data.
            state_d     = S_RESP;
            rdata_d     = '0;
            cpu_ready_d = 1'b1;
            err_set     = 1'b1;
          end else begin
            state_d = S_REQ;
            if (cpu_instr) begin
              ibus_valid_d = 1'b1;
            end else begin
              for (int i = 0; i < N_SLAVES; i++) begin
                dbus_valid_d[i] = (cpu_sel == SEL_W'(i));
              end
            end
          end
        end
      end

      S_REQ: begin
        if (tgt_ready) begin
          state_d      = S_RESP;
          rdata_d      = tgt_rdata;
          cpu_ready_d  = 1'b1;
          ibus_valid_d = 1'b0;
          dbus_valid_d = '0;
        end else if (tmo_hit) begin
          state_d      = S_RESP;
          rdata_d      = TMO_RDATA;
          cpu_ready_d  = 1'b1;
          ibus_valid_d = 1'b0;
          dbus_valid_d = '0;
          err_set      = 1'b1;
        end
      end

      S_RESP: begin
        // cpu_ready is high for this single cycle; the CPU request is not looked at.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new error wins over a clear arriving in the same cycle.
    if (err_set) begin
      bus_err_d = 1'b1;
    end else if (err_clr) begin
      bus_err_d = 1'b0;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // State and output registers; reset drops every valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      instr_q      <= 1'b0;
      sel_q        <= '0;
      ibus_valid_q <= 1'b0;
      dbus_valid_q <= '0;
      cpu_ready_q  <= 1'b0;
      rdata_q      <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      instr_q      <= instr_d;
      sel_q        <= sel_d;
      ibus_valid_q <= ibus_valid_d;
      dbus_valid_q <= dbus_valid_d;
      cpu_ready_q  <= cpu_ready_d;
      rdata_q      <= rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = rdata_q;
  assign ibus_valid = ibus_valid_q;
  assign dbus_valid = dbus_valid_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign m_wstrb    = m_wstrb_q;
  assign bus_err    = bus_err_q;

endmodule

// File: doc/iob_cpu_bridge.md
IOB_CPU_BRIDGE -- requirements
Module: iob_cpu_bridge

Interface
REQ-001 ADDR_W, 32, address width of the CPU and all target buses.
REQ-002 DATA_W, 32, data width; wstrb width is DATA_W/8.
REQ-003 N_SLAVES, 2, number of data-bus targets (>=2). SEL_W=$clog2(N_SLAVES). Select field = cpu_addr[ADDR_W-1 -: SEL_W].
REQ-004 TIMEOUT_CYC, 256, maximum REQ cycles before abort (used only with BUS_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cpu_valid  in  1  native CPU request valid, held until cpu_ready.
REQ-008 cpu_instr  in  1  1 = instruction fetch, 0 = data access.
REQ-009 cpu_addr  in  ADDR_W  request address.
REQ-010 cpu_wdata  in  DATA_W  write data.
REQ-011 cpu_wstrb  in  DATA_W/8  byte enables; 0 = read.
REQ-012 cpu_ready  out  1  one-cycle completion pulse.
REQ-013 cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1.
REQ-014 ibus_valid  out  1  instruction-bus request valid.
REQ-015 ibus_ready  in  1  instruction-bus completion.
REQ-016 ibus_rdata  in  DATA_W  instruction-bus read data.
REQ-017 dbus_valid  out  N_SLAVES  one-hot data-target request valid.
REQ-018 dbus_ready  in  N_SLAVES  per-target completion.
REQ-019 dbus_rdata  in  N_SLAVES*DATA_W  per-target read data; target i occupies bits [i*DATA_W +: DATA_W].
REQ-020 m_addr, m_wdata, m_wstrb  out  ADDR_W, DATA_W, DATA_W/8  registered request fields broadcast to all targets.
REQ-021 bus_err  out  1  sticky error flag.
REQ-022 err_clr  in  1  synchronous clear of bus_err.

Function
REQ-023 FSM with three states: IDLE, REQ, RESP.
REQ-024 IDLE transitions:
- cpu_valid=1 registers addr, wdata, wstrb, instr and target.
- Valid target: next state REQ.
- Data access with select >= N_SLAVES: next state RESP, rdata=0, bus_err set.
REQ-025 REQ drives exactly one valid, registered and glitch-free:
- instr=1: ibus_valid.
- Otherwise: dbus_valid[sel].
- The valid stays high until the selected ready is sampled 1.
REQ-026 REQ exit: on the selected ready, capture the matching rdata and move to RESP. Valid is 0 from the next cycle.
REQ-027 RESP asserts cpu_ready for exactly one cycle with the captured cpu_rdata, then returns to IDLE. cpu_valid is ignored during RESP.
REQ-028 Latency from cpu_valid to cpu_ready:
- Target ready in the first REQ cycle: 2 cycles minimum.
- Each extra wait cycle adds 1.
- Decode error: 1 cycle.
REQ-029 Back-to-back: cpu_valid asserted in the cycle after RESP is accepted in IDLE with no request lost or duplicated.
REQ-030 Outside REQ, all valids are 0. The ready and rdata of non-selected targets are ignored.
REQ-031 m_addr, m_wdata and m_wstrb stay stable for the whole REQ state.
REQ-032 bus_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.

Reset
REQ-033 While rst_n=0, asynchronously:
- State = IDLE.
- All valids, cpu_ready, cpu_rdata, m_* = 0.
- bus_err = 0; timeout counter = 0.
REQ-034 Reset during REQ drops the target valid immediately. No response is issued after reset is released.

Configuration
REQ-035 With IOB_CPU_BRIDGE_TIMEOUT_EN defined:
- A counter runs in REQ.
- After TIMEOUT_CYC cycles without ready, the target valid drops and the FSM enters RESP with rdata=32'hDEADBEEF (DATA_W low bits).
- bus_err is set.
REQ-036 Without the macro: no counter is synthesised, REQ waits indefinitely, and bus_err is set only by decode errors.

Verification (N_SLAVES=3, sel=addr[31:30])
REQ-037 Fetch at 0x00000100, ibus_ready 2 cycles after ibus_valid with rdata 0x00000013 -> cpu_ready single pulse, cpu_rdata=0x13, dbus_valid=0 throughout.
REQ-038 Write to 0x40000010 with wdata 0xA5A5A5A5 and wstrb 0xF -> dbus_valid=3'b010 until dbus_ready[1], m_wdata=0xA5A5A5A5, cpu_ready next cycle.
REQ-039 Read at 0xC0000000 -> no valid asserted, cpu_ready 1 cycle later with rdata 0, bus_err=1; err_clr pulse -> bus_err=0.
REQ-040 TIMEOUT_EN with TIMEOUT_CYC=8, dbus_ready[0] held 0 -> dbus_valid[0] drops after 8 cycles, cpu_rdata=0xDEADBEEF, bus_err=1. Without the macro, still waiting after 1000 cycles.
REQ-041 rst_n pulled low mid-REQ -> all outputs 0 immediately; after release, a read to 0x40000000 completes normally.
REQ-042 Three back-to-back requests (fetch, write, read) with cpu_valid reasserted right after each cpu_ready -> exactly three target valids and three cpu_ready pulses, in order.
